disp_scan_ctrl: RTL and testbench
=================================

# disp_scan_ctrl

Scan controller for the 10-digit, 2-bit-per-digit multiplexed display.
- Steps the 20-to-2 digit mux select through digits 0..9 at a programmable dwell rate.
- Drives one-hot digit enables with an anti-ghost blanking gap at each digit change.
- Holds the double-buffered 20-bit display image that feeds the mux inputs.
- Swaps in new data only at frame boundaries, so the display never tears.

## Interface
Parameters:
- PRESCALE, 1000: clock cycles per digit slot. Must be ≥ 2.
- BLANK_CYC, 16: cycles at the start of each slot with all digits off. Must satisfy 1 ≤ BLANK_CYC < PRESCALE.

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  scan enable; low forces IDLE
- load  input  1  one-cycle request to capture data_in into the shadow buffer
- data_in  input  20  new image; [2k+1:2k] is digit k (k = 0..9)
- busy  output  1  shadow buffer holds a pending image; a load is ignored while busy is high
- load_ack  output  1  one-cycle pulse: the pending image has become active
- act_data  output  20  active image, routed to mux inputs a..j (digit 0 = a … digit 9 = j)
- sel  output  4  mux select s3..s0; equals the current digit index, 0..9 only
- dig_en  output  10  one-hot digit enable, active high
- frame_done  output  1  one-cycle pulse on the last cycle of the digit-9 slot

## Operation
- States are IDLE, BLANK and SHOW.
- Reset values: IDLE, slot counter 0, sel 0, dig_en 0, act_data 0, shadow 0, busy 0, load_ack 0, frame_done 0.
- IDLE:
  - sel = 0 and dig_en = 0.
  - When en = 1, move to BLANK for digit 0 and clear the counter.
- BLANK:
  - dig_en = 0.
  - After BLANK_CYC cycles, move to SHOW.
- SHOW:
  - dig_en[sel] = 1.
  - On slot counter = PRESCALE-1, advance sel (9 wraps to 0) and move to BLANK.
- en = 0 in any state: on the next edge go to IDLE, with sel and dig_en = 0 and the counter cleared. A partial frame is abandoned and frame_done does not pulse.
- Load handshake:
  - load = 1 with busy = 0 captures data_in into the shadow buffer and sets busy.
  - load = 1 with busy = 1 is dropped; the shadow buffer is unchanged.
- Transfer:
  - Occurs on the frame_done cycle (SHOW, sel = 9, counter = PRESCALE-1), or on any cycle in IDLE, when busy = 1.
  - On that edge act_data takes the shadow value and busy clears.
  - load_ack is high for the following cycle.
- Load accepted on the same edge as a frame end: the shadow buffer is written, and the transfer waits for the next frame end. In IDLE it transfers on the next edge.
- sel never takes the values 10..15. dig_en is never more than one-hot.

## Timing
- Slot length: exactly PRESCALE cycles. BLANK lasts BLANK_CYC cycles, SHOW lasts PRESCALE − BLANK_CYC cycles.
- Frame length: 10·PRESCALE cycles.
- All outputs are registered.
- sel changes on the first BLANK cycle, so the mux has settled before any dig_en rises.
- en rising → first BLANK cycle one edge later. First dig_en[0] high BLANK_CYC cycles after that.
- load edge → busy high in the next cycle.
- Transfer edge → act_data updated and load_ack high in the same cycle, which is the first BLANK cycle of digit 0.
- rst_n assertion mid-frame or mid-handshake immediately forces all reset values. Any pending image is lost.

## Configuration
- Macro DISP_SCAN_LZB_EN enables leading-zero blanking.
- Defined: during SHOW for digit k ≥ 1, dig_en stays 0 if act_data digits k..9 are all zero. Digit 0 is always shown. sel still steps through every slot, so timing is unchanged.
- Undefined: every digit is shown during SHOW.

## Structure
- Package disp_scan_pkg holds:
  - NUM_DIGITS = 10, SEL_W = 4, DIG_W = 2
  - the state enum typedef (IDLE, BLANK, SHOW)
- Sub-module scan_prescaler:
  - Slot counter 0..PRESCALE-1 with synchronous clear.
  - Outputs blank_phase (counter < BLANK_CYC) and slot_end (counter = PRESCALE-1).
- The FSM, the buffers and the LZB logic sit in disp_scan_ctrl.

## Test plan
Bench parameters: PRESCALE = 8, BLANK_CYC = 2.
- Reset, then en = 1 → sel sequence 0,1,…,9,0. Each dig_en bit is high for 6 cycles after a 2-cycle gap. frame_done pulses every 80 cycles.
- load with data_in = 20'h3_9E4B mid-frame → busy high next cycle. act_data updates and load_ack pulses at the digit-0 BLANK following frame_done.
- Second load while busy → dropped. act_data equals the first image, and load_ack pulses exactly once.
- en dropped at sel = 5 → next cycle IDLE, sel = 0, dig_en = 0, no frame_done. A pending load transfers on the next edge.
- With DISP_SCAN_LZB_EN defined and data_in = 20'h0_0006 (digit 1 = 1, digit 0 = 2) → only dig_en[0] and dig_en[1] ever assert.
- Assert rst_n low mid-SHOW with busy = 1 → all outputs are 0 immediately, including busy and act_data.

Source files
------------

// File: rtl/disp_scan_pkg.sv
// Shared types and constants for the multiplexed display scan controller.
// Digit geometry, scan state encoding and digit decode helpers.
package disp_scan_pkg;

  localparam int NUM_DIGITS = 10;
  localparam int SEL_W      = 4;
  localparam int DIG_W      = 2;
  localparam int IMG_W      = NUM_DIGITS * DIG_W;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } scan_state_t;

  // One-hot enable for a digit index; out-of-range indices give zero.
  function automatic logic [NUM_DIGITS-1:0] digit_onehot(
    input logic [SEL_W-1:0] s
  );
    logic [NUM_DIGITS-1:0] oh;
    oh = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      oh[k] = (s == SEL_W'(k));
    end
    return oh;
  endfunction

  // A digit is lit unless it and every higher digit are zero.
  // Digit 0 is always lit so a blank image still shows a single 0.
  function automatic logic digit_lit(
    input logic [IMG_W-1:0] img,
    input logic [SEL_W-1:0] s
  );
    logic lit;
    lit = (s == '0);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (SEL_W'(k) >= s && img[k*DIG_W +: DIG_W] != '0) begin
        lit = 1'b1;
      end
    end
    return lit;
  endfunction

endpackage

// File: rtl/disp_scan_ctrl_prescaler.sv
// Digit slot timer: counts 0..PRESCALE-1 and flags the blank
// phase at the slot start and the final cycle of the slot.
module scan_prescaler #(
  parameter int PRESCALE  = 1000,
  parameter int BLANK_CYC = 16,
  parameter int CW        = $clog2(PRESCALE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          blank_phase,
  output logic          slot_end
);

  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLK  = CW'(BLANK_CYC);

  assign slot_end    = (cnt == LAST);
  assign blank_phase = (cnt < BLK);

  // Free-running slot counter, wraps each slot, cleared on demand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || slot_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Scan controller for the 10-digit multiplexed display with a
// double-buffered image. Optional DISP_SCAN_LZB_EN: leading-zero blanking.
module disp_scan_ctrl
  import disp_scan_pkg::*;
#(
  parameter int PRESCALE  = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [IMG_W-1:0]      data_in,
  output logic                  busy,
  output logic                  load_ack,
  output logic [IMG_W-1:0]      act_data,
  output logic [SEL_W-1:0]      sel,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic                  frame_done
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] PRE_LAST   = CW'(PRESCALE - 2);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_DIGITS - 1);

  scan_state_t           state;
  logic [IMG_W-1:0]      shadow;
  logic [CW-1:0]         cnt;
  logic                  blank_phase;
  logic                  slot_end;
  logic                  clr;
  logic                  xfer;
  logic                  last_digit;
  logic [SEL_W-1:0]      sel_next;
  logic [NUM_DIGITS-1:0] show_mask;

  assign clr        = !en || (state == IDLE);
  assign last_digit = (sel == SEL_LAST);
  assign sel_next   = last_digit ? '0 : sel + 1'b1;

  // The image swaps only at a frame end or while the scan is idle.
  assign xfer = busy &&
    ((state == SHOW && last_digit && slot_end) || state == IDLE);

  scan_prescaler #(
    .PRESCALE  (PRESCALE),
    .BLANK_CYC (BLANK_CYC),
    .CW        (CW)
  ) u_pre (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .cnt         (cnt),
    .blank_phase (blank_phase),
    .slot_end    (slot_end)
  );

  // Digit enable pattern to apply when the current slot enters SHOW.
  always_comb begin
    show_mask = digit_onehot(sel);
`ifdef DISP_SCAN_LZB_EN
    if (!digit_lit(act_data, sel)) begin
      show_mask = '0;
    end
`endif
  end

  // Scan FSM plus the load/transfer handshake, all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= '0;
      dig_en     <= '0;
      act_data   <= '0;
      shadow     <= '0;
      busy       <= 1'b0;
      load_ack   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      load_ack   <= xfer;
      frame_done <= en && (state != IDLE) &&
                    last_digit && (cnt == PRE_LAST);

      if (xfer) begin
        act_data <= shadow;
        busy     <= 1'b0;
      end else if (load && !busy) begin
        shadow <= data_in;
        busy   <= 1'b1;
      end

      if (!en) begin
        state  <= IDLE;
        sel    <= '0;
        dig_en <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            state  <= BLANK;
            sel    <= '0;
            dig_en <= '0;
          end
          BLANK: begin
            if (blank_phase && cnt == BLANK_LAST) begin
              state  <= SHOW;
              dig_en <= show_mask;
            end
          end
          SHOW: begin
            if (slot_end) begin
              state  <= BLANK;
              sel    <= sel_next;
              dig_en <= '0;
            end
          end
          default: begin
            state  <= IDLE;
            sel    <= '0;
            dig_en <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with PRESCALE=8, BLANK_CYC=2.
// Honours DISP_SCAN_LZB_EN when the design is built with it.
module tb_disp_scan_ctrl;

  localparam int P = 8;
  localparam int B = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [19:0] data_in = '0;
  logic        busy;
  logic        load_ack;
  logic [19:0] act_data;
  logic [3:0]  sel;
  logic [9:0]  dig_en;
  logic        frame_done;

  int tests = 0;
  int fails = 0;
  int ph = 0;
  int bad = 0;
  logic [19:0] img = '0;

  disp_scan_ctrl #(.PRESCALE(P), .BLANK_CYC(B)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .data_in    (data_in),
    .busy       (busy),
    .load_ack   (load_ack),
    .act_data   (act_data),
    .sel        (sel),
    .dig_en     (dig_en),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && (sel > 4'd9 || !$onehot0(dig_en))) bad++;
  end

  function automatic bit vis(int k, logic [19:0] im);
`ifdef DISP_SCAN_LZB_EN
    if (k == 0) return 1'b1;
    for (int j = k; j < 10; j++) begin
      if (im[2*j +: 2] != 2'b00) return 1'b1;
    end
    return 1'b0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [9:0] exp_en(int p, logic [19:0] im);
    int k;
    k = (p / P) % 10;
    if ((p % P) >= B && vis(k, im)) return 10'd1 << k;
    return 10'd0;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic advance(int n);
    for (int i = 0; i < n; i++) begin
      step();
      ph++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) step();
    tests++;
    if ({sel, dig_en, act_data, busy, load_ack, frame_done} !== '0) begin
      fails++;
      $display("FAIL reset: sel=%0d dig_en=%b act=%h busy=%b ack=%b fd=%b",
               sel, dig_en, act_data, busy, load_ack, frame_done);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_scan;
    int k;
    en = 1'b1;
    step();
    ph = 0;
    for (int i = 0; i < 90; i++) begin
      k = (ph / P) % 10;
      tests++;
      if (sel !== 4'(k) || dig_en !== exp_en(ph, img) ||
          frame_done !== ((ph % 80) == 79)) begin
        fails++;
        $display("FAIL scan ph=%0d: sel=%0d/%0d dig_en=%b/%b fd=%b",
                 ph, sel, k, dig_en, exp_en(ph, img), frame_done);
      end
      advance(1);
    end
  endtask

  task automatic test_load;
    int acks;
    load = 1'b1;
    data_in = 20'h3_9E4B;
    advance(1);
    load = 1'b0;
    tests++;
    if (busy !== 1'b1 || load_ack !== 1'b0 || act_data !== 20'h0) begin
      fails++;
      $display("FAIL load_capture: busy=%b ack=%b act=%h, want 1 0 00000",
               busy, load_ack, act_data);
    end
    load = 1'b1;
    data_in = 20'h1_2345;
    advance(1);
    load = 1'b0;
    acks = 0;
    for (int i = 0; i < 200; i++) begin
      if (load_ack === 1'b1) begin
        acks++;
        tests++;
        if ((ph % 80) != 0 || act_data !== 20'h3_9E4B || busy !== 1'b0) begin
          fails++;
          $display("FAIL load_xfer: ph=%0d act=%h busy=%b, want ph%%80=0 39e4b 0",
                   ph, act_data, busy);
        end
      end
      advance(1);
    end
    img = 20'h3_9E4B;
    tests++;
    if (acks != 1 || act_data !== 20'h3_9E4B) begin
      fails++;
      $display("FAIL load_drop: acks=%0d act=%h, want 1 39e4b",
               acks, act_data);
    end
  endtask

  task automatic test_en_drop;
    int viol;
    while ((ph % 80) != 24) advance(1);
    load = 1'b1;
    data_in = 20'hA_BCDE;
    advance(1);
    load = 1'b0;
    while ((ph % 80) != 43) advance(1);
    tests++;
    if (sel !== 4'd5 || busy !== 1'b1) begin
      fails++;
      $display("FAIL en_pre: sel=%0d busy=%b, want 5 1", sel, busy);
    end
    en = 1'b0;
    step();
    tests++;
    if (sel !== 4'd0 || dig_en !== 10'd0 || frame_done !== 1'b0 ||
        busy !== 1'b1 || load_ack !== 1'b0) begin
      fails++;
      $display("FAIL en_drop: sel=%0d dig_en=%b fd=%b busy=%b ack=%b",
               sel, dig_en, frame_done, busy, load_ack);
    end
    step();
    tests++;
    if (load_ack !== 1'b1 || act_data !== 20'hA_BCDE || busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_xfer: ack=%b act=%h busy=%b, want 1 abcde 0",
               load_ack, act_data, busy);
    end
    viol = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (frame_done !== 1'b0 || sel !== 4'd0 || dig_en !== 10'd0) viol++;
    end
    tests++;
    if (viol != 0) begin
      fails++;
      $display("FAIL idle_hold: %0d bad cycles, want 0", viol);
    end
    load = 1'b1;
    data_in = 20'h0_0006;
    step();
    load = 1'b0;
    tests++;
    if (busy !== 1'b1 || act_data !== 20'hA_BCDE) begin
      fails++;
      $display("FAIL idle_load: busy=%b act=%h, want 1 abcde", busy, act_data);
    end
    step();
    tests++;
    if (load_ack !== 1'b1 || act_data !== 20'h0_0006 || busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_load_xfer: ack=%b act=%h busy=%b, want 1 00006 0",
               load_ack, act_data, busy);
    end
    img = 20'h0_0006;
  endtask

  task automatic test_back_to_back;
    int viol;
    en = 1'b1;
    step();
    ph = 0;
    viol = 0;
    for (int i = 0; i < 79; i++) begin
      if (dig_en !== exp_en(ph, img)) viol++;
      advance(1);
    end
    tests++;
    if (viol != 0) begin
      fails++;
      $display("FAIL lzb_frame: %0d bad cycles, want 0", viol);
    end
    tests++;
    if (frame_done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL frame_end: fd=%b busy=%b, want 1 0", frame_done, busy);
    end
    load = 1'b1;
    data_in = 20'h5_5555;
    advance(1);
    load = 1'b0;
    tests++;
    if (busy !== 1'b1 || load_ack !== 1'b0 || act_data !== 20'h0_0006) begin
      fails++;
      $display("FAIL edge_load: busy=%b ack=%b act=%h, want 1 0 00006",
               busy, load_ack, act_data);
    end
    advance(79);
    tests++;
    if (busy !== 1'b1 || load_ack !== 1'b0 || frame_done !== 1'b1) begin
      fails++;
      $display("FAIL edge_wait: busy=%b ack=%b fd=%b, want 1 0 1",
               busy, load_ack, frame_done);
    end
    advance(1);
    tests++;
    if (load_ack !== 1'b1 || act_data !== 20'h5_5555 || busy !== 1'b0) begin
      fails++;
      $display("FAIL edge_xfer: ack=%b act=%h busy=%b, want 1 55555 0",
               load_ack, act_data, busy);
    end
    img = 20'h5_5555;
  endtask

  task automatic test_reset_mid;
    load = 1'b1;
    data_in = 20'h1_1111;
    advance(1);
    load = 1'b0;
    advance(3);
    tests++;
    if (busy !== 1'b1 || dig_en !== 10'd1) begin
      fails++;
      $display("FAIL pre_rst: busy=%b dig_en=%b, want 1 0000000001",
               busy, dig_en);
    end
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({sel, dig_en, act_data, busy, load_ack, frame_done} !== '0) begin
      fails++;
      $display("FAIL async_rst: sel=%0d dig_en=%b act=%h busy=%b ack=%b fd=%b",
               sel, dig_en, act_data, busy, load_ack, frame_done);
    end
    step();
    rst_n = 1'b1;
    en = 1'b0;
    step();
    tests++;
    if (busy !== 1'b0 || act_data !== 20'h0 || load_ack !== 1'b0) begin
      fails++;
      $display("FAIL post_rst: busy=%b act=%h ack=%b, want 0 00000 0",
               busy, act_data, load_ack);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_en_drop();
    test_back_to_back();
    test_reset_mid();
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL sel_onehot: %0d bad cycles, want 0", bad);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
